// File: rtl/gate_truth_checker.sv
// Exhaustive truth-table checker: walks every input vector through a gate-under-test,
// samples after SETTLE cycles, compares against TRUTH. No backpressure; start ignored while busy.
module gate_truth_checker #(
  parameter int                 N_IN   = 2,
  parameter logic [2**N_IN-1:0] TRUTH  = 4'b1110,
  parameter int                 SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail_vec
);

  localparam logic [N_IN-1:0] LAST_VEC   = '1;
  localparam logic [3:0]      SETTLE_CNT = SETTLE[3:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       accept;
  logic       sample;
  logic       mismatch;
  logic       last_vec;

  always_comb begin
    accept   = (state == S_IDLE) && start;
    sample   = (state == S_RUN) && (cnt == 4'd0);
    mismatch = sample && (dut_y != TRUTH[dut_in]);
    last_vec = (dut_in == LAST_VEC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (sample && last_vec) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // busy covers exactly the RUN state, so it drops on the same edge done rises
  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dut_in         <= '0;
      cnt            <= 4'd0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
      pass           <= 1'b0;
    end else if (accept) begin
      dut_in         <= '0;
      cnt            <= SETTLE_CNT;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
      pass           <= 1'b0;
    end else if (state == S_RUN) begin
      if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end else begin
        if (mismatch) begin
          err_count <= err_count + 1'b1;
          if (!fail_valid) begin
            first_fail_vec <= dut_in;
            fail_valid     <= 1'b1;
          end
        end
        // final verdict must include the sample taken on this very edge
        if (!last_vec) begin
          dut_in <= dut_in + 1'b1;
          cnt    <= SETTLE_CNT;
        end else begin
          pass <= (err_count == '0) && !mismatch;
        end
      end
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: three configurations driven by table-based gate models,
// results compared with expectations derived directly from the gate and golden tables.
module tb_gate_truth_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start;
  logic [7:0] gtab [3];

  logic [1:0] din0, ffv0;
  logic [2:0] err0;
  logic       y0, busy0, done0, pass0, fv0;
  logic [2:0] din1, ffv1, din2, ffv2;
  logic [3:0] err1, err2;
  logic       y1, busy1, done1, pass1, fv1;
  logic       y2, busy2, done2, pass2, fv2;

  int total = 0;
  int bad   = 0;
  int sel   = 0;

  logic [2:0] m_din, m_ffv;
  logic [3:0] m_err;
  logic       m_busy, m_done, m_pass, m_fv;

  always #5 clk = ~clk;

  assign y0 = gtab[0][din0];
  assign y1 = gtab[1][din1];
  assign y2 = gtab[2][din2];

  gate_truth_checker #(.N_IN(2), .TRUTH(4'b1110), .SETTLE(2)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .dut_in(din0), .dut_y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_valid(fv0), .first_fail_vec(ffv0));

  gate_truth_checker #(.N_IN(3), .TRUTH(8'h96), .SETTLE(0)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .dut_in(din1), .dut_y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .first_fail_vec(ffv1));

  gate_truth_checker #(.N_IN(3), .TRUTH(8'h97), .SETTLE(0)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .dut_in(din2), .dut_y(y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_valid(fv2), .first_fail_vec(ffv2));

  always_comb begin
    m_din = {1'b0, din0}; m_ffv = {1'b0, ffv0}; m_err = {1'b0, err0};
    m_busy = busy0; m_done = done0; m_pass = pass0; m_fv = fv0;
    if (sel == 1) begin
      m_din = din1; m_ffv = ffv1; m_err = err1;
      m_busy = busy1; m_done = done1; m_pass = pass1; m_fv = fv1;
    end else if (sel == 2) begin
      m_din = din2; m_ffv = ffv2; m_err = err2;
      m_busy = busy2; m_done = done2; m_pass = pass2; m_fv = fv2;
    end
  end

  // kind: 0 = 2-input OR, 1 = 2-input AND, 2 = stuck at 0, 3 = 3-input XOR
  function automatic logic [7:0] make_tab(input int kind);
    logic [7:0] t;
    t = '0;
    for (int v = 0; v < 8; v++) begin
      case (kind)
        0:       t[v] = v[0] | v[1];
        1:       t[v] = v[0] & v[1];
        2:       t[v] = 1'b0;
        default: t[v] = v[0] ^ v[1] ^ v[2];
      endcase
    end
    return t;
  endfunction

  function automatic logic [7:0] truth_of(input int k);
    if (k == 0) return 8'h0E;
    if (k == 1) return 8'h96;
    return 8'h97;
  endfunction

  task automatic run_check(input int k, input bit noisy, input string nm);
    int nv, hold, nexp, done_at, exp_err, exp_ffv;
    logic [7:0] tr;
    bit seq_ok;
    nv   = (k == 0) ? 4 : 8;
    hold = (k == 0) ? 3 : 1;
    nexp = nv * hold;
    tr   = truth_of(k);
    exp_err = 0;
    exp_ffv = 0;
    for (int v = nv - 1; v >= 0; v--) begin
      if (gtab[k][v] !== tr[v]) begin
        exp_err++;
        exp_ffv = v;
      end
    end
    sel = k;
    @(negedge clk);
    start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    total++;
    if (m_busy !== 1'b1 || m_din !== 3'd0 || m_err !== 4'd0 || m_fv !== 1'b0 || m_pass !== 1'b0) begin
      bad++;
      $display("FAIL %s accept: busy=%b din=%0d err=%0d fv=%b pass=%b want 1,0,0,0,0",
               nm, m_busy, m_din, m_err, m_fv, m_pass);
    end
    seq_ok  = 1'b1;
    done_at = -1;
    for (int c = 1; c <= nexp + 10 && done_at < 0; c++) begin
      if (noisy) begin
        @(negedge clk);
        start[k] = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      if (m_done === 1'b1) done_at = c;
      else if (c < nexp && (m_busy !== 1'b1 || m_din !== 3'(c / hold))) seq_ok = 1'b0;
    end
    start[k] = 1'b0;
    total++;
    if (done_at != nexp) begin
      bad++;
      $display("FAIL %s done_latency: got %0d want %0d (-1 = timeout)", nm, done_at, nexp);
    end
    total++;
    if (!seq_ok) begin
      bad++;
      $display("FAIL %s vector_sequence: got out-of-order or wrongly held vector, want each held %0d cycles", nm, hold);
    end
    total++;
    if (m_busy !== 1'b0 || m_din !== 3'(nv - 1)) begin
      bad++;
      $display("FAIL %s at_done: busy=%b din=%0d want 0,%0d", nm, m_busy, m_din, nv - 1);
    end
    total++;
    if (m_err !== 4'(exp_err)) begin
      bad++;
      $display("FAIL %s err_count: got %0d want %0d", nm, m_err, exp_err);
    end
    total++;
    if (m_fv !== (exp_err > 0) || m_ffv !== 3'(exp_ffv)) begin
      bad++;
      $display("FAIL %s first_fail: got fv=%b vec=%0d want fv=%b vec=%0d",
               nm, m_fv, m_ffv, (exp_err > 0), exp_ffv);
    end
    total++;
    if (m_pass !== (exp_err == 0)) begin
      bad++;
      $display("FAIL %s pass: got %b want %b", nm, m_pass, (exp_err == 0));
    end
    @(posedge clk); #1;
    total++;
    if (m_done !== 1'b0 || m_busy !== 1'b0 || m_err !== 4'(exp_err) || m_pass !== (exp_err == 0)) begin
      bad++;
      $display("FAIL %s after_done: done=%b busy=%b err=%0d pass=%b want 0,0,%0d,%b",
               nm, m_done, m_busy, m_err, m_pass, exp_err, (exp_err == 0));
    end
    @(posedge clk); #1;
    total++;
    if (m_done !== 1'b0 || m_busy !== 1'b0 || m_din !== 3'(nv - 1)) begin
      bad++;
      $display("FAIL %s idle_hold: done=%b busy=%b din=%0d want 0,0,%0d", nm, m_done, m_busy, m_din, nv - 1);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy0, done0, pass0, fv0, din0, err0, ffv0} !== '0) begin
      bad++;
      $display("FAIL reset_u0: got %b want all zero", {busy0, done0, pass0, fv0, din0, err0, ffv0});
    end
    total++;
    if ({busy1, done1, pass1, fv1, din1, err1, ffv1, busy2, done2, pass2, fv2, din2, err2, ffv2} !== '0) begin
      bad++;
      $display("FAIL reset_u12: got nonzero outputs, want all zero");
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0 || done0 !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_idle: busy0=%b busy1=%b done0=%b want 0", busy0, busy1, done0);
    end
  endtask

  task automatic test_or_gate;
    gtab[0] = make_tab(0);
    run_check(0, 1'b0, "or_gate");
  endtask

  task automatic test_stuck_zero;
    gtab[0] = make_tab(2);
    run_check(0, 1'b0, "stuck_zero");
  endtask

  task automatic test_and_then_or;
    gtab[0] = make_tab(1);
    run_check(0, 1'b0, "and_gate");
    gtab[0] = make_tab(0);
    run_check(0, 1'b0, "or_after_and");
  endtask

  task automatic test_extra_starts;
    gtab[0] = make_tab(0);
    run_check(0, 1'b1, "extra_starts");
  endtask

  task automatic test_start_held;
    int n;
    bit saw;
    sel = 0;
    gtab[0] = make_tab(0);
    @(negedge clk);
    start[0] = 1'b1;
    saw = 1'b0;
    for (n = 0; n < 40 && !saw; n++) begin
      @(posedge clk); #1;
      if (done0 === 1'b1) saw = 1'b1;
    end
    @(posedge clk); #1;
    total++;
    if (!saw || busy0 !== 1'b0) begin
      bad++;
      $display("FAIL held_gap: saw_done=%b busy=%b want 1,0", saw, busy0);
    end
    @(posedge clk); #1;
    total++;
    if (busy0 !== 1'b1 || din0 !== 2'd0 || err0 !== 3'd0) begin
      bad++;
      $display("FAIL held_restart: busy=%b din=%0d err=%0d want 1,0,0", busy0, din0, err0);
    end
    start[0] = 1'b0;
    saw = 1'b0;
    for (n = 0; n < 40 && !saw; n++) begin
      @(posedge clk); #1;
      if (done0 === 1'b1) saw = 1'b1;
    end
    total++;
    if (!saw || pass0 !== 1'b1) begin
      bad++;
      $display("FAIL held_second_run: saw_done=%b pass=%b want 1,1", saw, pass0);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid_run;
    bit saw_done;
    sel = 0;
    gtab[0] = make_tab(2);
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    total++;
    if (din0 !== 2'd2 || err0 !== 3'd1 || fv0 !== 1'b1) begin
      bad++;
      $display("FAIL midrun_state: din=%0d err=%0d fv=%b want 2,1,1", din0, err0, fv0);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy0, done0, pass0, fv0, din0, err0, ffv0} !== '0) begin
      bad++;
      $display("FAIL async_reset: got %b want all zero", {busy0, done0, pass0, fv0, din0, err0, ffv0});
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done0 !== 1'b0 || busy0 !== 1'b0) saw_done = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done0 !== 1'b0 || busy0 !== 1'b0) saw_done = 1'b1;
    end
    total++;
    if (saw_done) begin
      bad++;
      $display("FAIL reset_no_done: got done/busy activity after reset, want none");
    end
    gtab[0] = make_tab(0);
    run_check(0, 1'b0, "post_reset_run");
  endtask

  task automatic test_xor3;
    gtab[1] = make_tab(3);
    gtab[2] = make_tab(3);
    run_check(1, 1'b0, "xor3_96");
    run_check(2, 1'b0, "xor3_97");
  endtask

  task automatic test_random;
    int k;
    for (int i = 0; i < 12; i++) begin
      k = $urandom_range(0, 2);
      gtab[k] = 8'($urandom);
      if ($urandom_range(0, 2) == 0) gtab[k] = truth_of(k);
      run_check(k, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    start = '0;
    gtab[0] = '0;
    gtab[1] = '0;
    gtab[2] = '0;
    test_reset();
    test_or_gate();
    test_stuck_zero();
    test_and_then_or();
    test_extra_starts();
    test_start_held();
    test_reset_mid_run();
    test_xor3();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
